multicycle_control: RTL

Multi-cycle main control FSM for the Green CPU datapath. Fetches a 16-bit instruction over a ready-handshaked memory port, latches it into an internal instruction register and decodes it. It then sequences execute, memory and writeback, driving the datapath enables. It is the producer of the `ALUOp`/`funct` pair consumed by `alu_decoder`, and it also implements a low-power HALT state with an external wake.

---
 rtl/multicycle_control.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the Green CPU: fetch, decode, execute,
// memory and writeback sequencing plus a HALT state with external wake.
module multicycle_control #(
    parameter int IW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] mem_rdata,
    input  logic          mem_ready,
    input  logic          wake,
    output logic          mem_req,
    output logic          mem_we,
    output logic          mem_addr_sel,
    output logic          pc_we,
    output logic          reg_we,
    output logic          wb_sel_mem,
    output logic          alu_src_imm,
    output logic [1:0]    ALUOp,
    output logic [3:0]    funct,
    output logic [2:0]    rd,
    output logic [2:0]    rs,
    output logic [2:0]    rt,
    output logic [5:0]    imm6,
    output logic          halted,
    output logic          illegal_instr,
    output logic          instr_done,
    output logic [2:0]    state_o
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LH    = 4'b0001;
    localparam logic [3:0] OP_SH    = 4'b0010;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    state_t        state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          is_r, is_lh, is_sh, is_halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign is_r    = (ir_q[15:12] == OP_RTYPE);
    assign is_lh   = (ir_q[15:12] == OP_LH);
    assign is_sh   = (ir_q[15:12] == OP_SH);
    assign is_halt = (ir_q[15:12] == OP_HALT);

    // Fields come straight from the ir, so they read 0 while it is cleared by reset.
    assign funct   = {1'b0, ir_q[2:0]};
    assign rd      = ir_q[11:9];
    assign rs      = ir_q[8:6];
    assign rt      = ir_q[5:3];
    assign imm6    = ir_q[5:0];
    assign state_o = state_q;

    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        pc_we         = 1'b0;
        reg_we        = 1'b0;
        wb_sel_mem    = 1'b0;
        alu_src_imm   = 1'b0;
        ALUOp         = 2'b00;
        halted        = 1'b0;
        illegal_instr = 1'b0;
        instr_done    = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_r || is_lh || is_sh) begin
                    state_d = S_EXEC;
                end else if (is_halt) begin
                    instr_done = 1'b1;
                    state_d    = S_HALT;
                end else begin
                    // Undefined opcodes retire as a NOP.
                    illegal_instr = 1'b1;
                    instr_done    = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_EXEC: begin
                if (is_r) begin
                    ALUOp   = 2'b10;
                    state_d = S_WB;
                end else begin
                    alu_src_imm = 1'b1;
                    state_d     = S_MEM;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_sh;
                alu_src_imm  = 1'b1;
                if (mem_ready) begin
                    if (is_lh) begin
                        state_d = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                wb_sel_mem = is_lh;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (wake) state_d = S_FETCH;
            end
            default: state_d = S_RESET;
        endcase
    end

endmodule
